// File: rtl/para_ctrl.sv
// rtl/para_ctrl.sv - measurement control FSM gating sampler strobes and reporting ring values.
// Optional timeout support compiled in with `define PARA_CTRL_TIMEOUT_EN.
module para_ctrl (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic        cfg_auto,
  input  logic [15:0] cfg_win,
  input  logic [15:0] sm_data_in,
  input  logic        sm_vld_in,
  output logic [15:0] sm_data_out,
  output logic        sm_vld_out,
  input  logic        stu_now_lock,
  input  logic [15:0] stu_ring,
  output logic [15:0] ph_ring,
  output logic        ph_vld,
  input  logic        ph_rdy,
  output logic [2:0]  stu_state,
  output logic [15:0] stu_rpt_cnt,
  output logic        stu_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    RUN    = 3'd2,
    LOCK   = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ring_q, ring_d;
  logic [15:0] rpt_q, rpt_d;
  logic [15:0] cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        win_hit;

  assign sm_data_out = sm_data_in;
  assign sm_vld_out  = ((state_q == RUN) || (state_q == LOCK)) ? sm_vld_in : 1'b0;
  assign ph_vld      = (state_q == REPORT);
  assign ph_ring     = ring_q;
  assign stu_state   = state_q;
  assign stu_rpt_cnt = rpt_q;

`ifdef PARA_CTRL_TIMEOUT_EN
  // A saturated counter can no longer "reach" the window, so exclude it.
  assign win_hit     = sm_vld_out && (cfg_win != 16'd0) && (cnt_q != 16'hFFFF)
                       && ((cnt_q + 16'd1) == cfg_win);
  assign stu_timeout = to_q;
`else
  logic unused_win;
  assign unused_win  = ^cfg_win;
  assign win_hit     = 1'b0;
  assign stu_timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ring_q  <= 16'd0;
      rpt_q   <= 16'd0;
      cnt_q   <= 16'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      rpt_q   <= rpt_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    rpt_d   = rpt_q;
    cnt_d   = cnt_q;
    to_d    = to_q;

    if (sm_vld_out && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;

    if (cfg_stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (cfg_start) state_d = ARM;
        ARM: begin
          cnt_d   = 16'd0;
          to_d    = 1'b0;
          state_d = RUN;
        end
        RUN: begin
          if (win_hit) begin
            state_d = REPORT;
            ring_d  = 16'hFFFF;
            to_d    = 1'b1;
          end else if (stu_now_lock) begin
            state_d = LOCK;
          end
        end
        LOCK: begin
          // Lock fall outranks a coincident timeout.
          if (!stu_now_lock) begin
            state_d = REPORT;
            ring_d  = stu_ring;
          end else if (win_hit) begin
            state_d = REPORT;
            ring_d  = 16'hFFFF;
            to_d    = 1'b1;
          end
        end
        REPORT: begin
          if (ph_rdy) begin
            rpt_d   = rpt_q + 16'd1;
            state_d = cfg_auto ? ARM : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
